// File: rtl/mux_rr_arbiter_pkg.sv
// ============================================================================
// mux_rr_arbiter_pkg : shared types and sizes for the round-robin mux arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package mux_rr_arbiter_pkg;

   localparam int N_REQ        = 4;
   localparam int SEL_W        = 2;
   localparam int MAX_HOLD_DEF = 20;
   localparam int HOLD_W       = $clog2(MAX_HOLD_DEF + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GUARD = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/mux_rr_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : combinational round-robin picker, search starts at ptr+1 and wraps
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick
   import mux_rr_arbiter_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic             valid,
   output logic [SEL_W-1:0] idx
);

   logic [SEL_W-1:0] cand;

   // Scan from the farthest offset down so the nearest requester wins last.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         cand = ptr + SEL_W'(k + 1);
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
// ============================================================================
// mux_rr_arbiter : round-robin N:1 mux arbiter with hold limit and guard cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux_rr_arbiter #(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [1:0]       s,
   output logic             ctrl,
   output logic             busy
);

   import mux_rr_arbiter_pkg::*;

   localparam int             CNT_W    = $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [1:0]       last, last_d;
   logic [N_REQ-1:0] gnt_d;
   logic [1:0]       s_d;
   logic             ctrl_d, busy_d;

   logic             pick_valid;
   logic [1:0]       pick_idx;
   logic             at_max, others, release_now;

   rr_pick u_pick (
      .req   (req),
      .ptr   (last),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   assign at_max      = (cnt == HOLD_MAX);
   assign others      = |(req & ~gnt);
   assign release_now = !req[s] || (at_max && others);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         last  <= 2'd3;
         gnt   <= '0;
         s     <= 2'b00;
         ctrl  <= 1'b0;
         busy  <= 1'b0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         last  <= last_d;
         gnt   <= gnt_d;
         s     <= s_d;
         ctrl  <= ctrl_d;
         busy  <= busy_d;
      end
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (pick_valid) state_d = GRANT;
         GRANT:   if (release_now) state_d = GUARD;
         GUARD:   state_d = pick_valid ? GRANT : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs; s is kept through GUARD and IDLE.
   always_comb begin
      gnt_d  = gnt;
      s_d    = s;
      ctrl_d = ctrl;
      cnt_d  = cnt;
      last_d = last;
      if (state_d == GRANT && state != GRANT) begin
         gnt_d  = N_REQ'(1) << pick_idx;
         s_d    = pick_idx;
         ctrl_d = 1'b1;
         cnt_d  = CNT_W'(1);
         last_d = pick_idx;
      end else if (state_d == GRANT) begin
         cnt_d = at_max ? cnt : cnt + CNT_W'(1);
      end else begin
         gnt_d  = '0;
         ctrl_d = 1'b0;
         cnt_d  = '0;
      end
      busy_d = (state_d != IDLE);
   end

endmodule

`default_nettype wire
